ascii_digit_packer: RTL and testbench

- Upstream stage for the ASCII-to-BCD converter.
- Accepts one ASCII character per handshake from a byte stream (UART/keypad front end) and packs DIGITS decimal characters into one 8*DIGITS-bit word.
- The packed word is right-justified: first-received character in the most-significant byte, unused leading bytes padded with ASCII '0' (8'h30).
- Non-digit characters other than the terminator are rejected and flagged, so the converter only ever sees words of valid digits.

---
 rtl/ascii_digit_packer_if.sv | 23 ++
 rtl/ascii_digit_packer.sv | 107 ++++++++++
 tb/tb_ascii_digit_packer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ascii_digit_packer_if.sv
// Byte-in / word-out handshake bundle for ascii_digit_packer.
// master = byte source and word consumer side, slave = packer side.
interface ascii_digit_packer_if #(
  parameter int unsigned DIGITS = 4
);
  logic [7:0]          in_byte;
  logic                in_valid;
  logic                in_ready;
  logic [8*DIGITS-1:0] ASCII;
  logic                out_valid;
  logic                out_ready;
  logic                err;

  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, ASCII, out_valid, err
  );

  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, ASCII, out_valid, err
  );
endinterface

// File: rtl/ascii_digit_packer.sv
// Packs DIGITS ASCII decimal characters into one right-justified word padded with '0'.
// Optional macro ASCII_PACK_ERRCNT_EN adds a saturating illegal-character counter (err_count).
module ascii_digit_packer #(
  parameter int unsigned DIGITS = 4,
  parameter logic [7:0]  TERM   = 8'h0D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ascii_digit_packer_if.slave  bus
`ifdef ASCII_PACK_ERRCNT_EN
  ,
  output logic [7:0]           err_count
`endif
);

  localparam int unsigned         CNT_W    = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(DIGITS);
  localparam logic [8*DIGITS-1:0] PAD      = {DIGITS{8'h30}};

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t              r_state, w_state_n;
  logic [CNT_W-1:0]    r_count, w_count_n, w_count_inc;
  logic [8*DIGITS-1:0] r_ascii, w_ascii_n, w_shifted;
  logic                r_err, w_err_n;
  logic                w_in_fire, w_is_digit;

  // The new character enters the least-significant byte; older ones move up.
  generate
    if (DIGITS > 1) begin : g_shift
      assign w_shifted = {r_ascii[8*DIGITS-9:0], bus.in_byte};
    end else begin : g_single
      assign w_shifted = bus.in_byte;
    end
  endgenerate

  assign w_in_fire   = bus.in_valid && (r_state == COLLECT);
  assign w_is_digit  = (bus.in_byte >= 8'h30) && (bus.in_byte <= 8'h39);
  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_count <= '0;
      r_ascii <= PAD;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_ascii <= w_ascii_n;
      r_err   <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_ascii_n = r_ascii;
    w_err_n   = 1'b0;
    unique case (r_state)
      COLLECT: begin
        if (w_in_fire) begin
          if (w_is_digit) begin
            w_ascii_n = w_shifted;
            w_count_n = w_count_inc;
            if (w_count_inc == CNT_FULL) w_state_n = HOLD;
          end else if (bus.in_byte == TERM) begin
            // Terminator on an empty word is silently dropped.
            if (r_count != '0) w_state_n = HOLD;
          end else begin
            w_err_n   = 1'b1;
            w_ascii_n = PAD;
            w_count_n = '0;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_ascii_n = PAD;
          w_count_n = '0;
          w_state_n = COLLECT;
        end
      end
      default: w_state_n = COLLECT;
    endcase
  end

  assign bus.in_ready  = (r_state == COLLECT);
  assign bus.out_valid = (r_state == HOLD);
  assign bus.ASCII     = r_ascii;
  assign bus.err       = r_err;

`ifdef ASCII_PACK_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (r_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_ascii_digit_packer.sv
// Directed self-checking bench for ascii_digit_packer (default DIGITS=4, TERM=8'h0D).
module tb_ascii_digit_packer;

  logic clk;
  logic rst_n;
  int unsigned total;
  int unsigned bad;

  ascii_digit_packer_if #(.DIGITS(4)) bus ();

`ifdef ASCII_PACK_ERRCNT_EN
  logic [7:0] err_count;
`endif

  ascii_digit_packer #(
    .DIGITS(4),
    .TERM  (8'h0D)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
`ifdef ASCII_PACK_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so registered outputs can be sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.in_byte   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    step();
    step();
    check("rst_ascii", 64'(bus.ASCII), 64'h30303030);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // 1: full word back-to-back, consumer always ready
    bus.out_ready = 1'b1;
    send(8'h31);
    send(8'h32);
    send(8'h33);
    check("t1_not_yet_valid", 64'(bus.out_valid), 64'd0);
    send(8'h34);
    bus.in_valid = 1'b0;
    check("t1_out_valid", 64'(bus.out_valid), 64'd1);
    check("t1_ascii", 64'(bus.ASCII), 64'h31323334);
    check("t1_in_ready_low", 64'(bus.in_ready), 64'd0);
    step();
    check("t1_out_valid_drop", 64'(bus.out_valid), 64'd0);
    check("t1_in_ready_back", 64'(bus.in_ready), 64'd1);
    check("t1_ascii_cleared", 64'(bus.ASCII), 64'h30303030);

    // 2: short word closed by terminator, then lone terminator
    send(8'h35);
    send(8'h37);
    send(8'h0D);
    bus.in_valid = 1'b0;
    check("t2_out_valid", 64'(bus.out_valid), 64'd1);
    check("t2_ascii", 64'(bus.ASCII), 64'h30303537);
    step();
    send(8'h0D);
    bus.in_valid = 1'b0;
    check("t2_lone_term_valid", 64'(bus.out_valid), 64'd0);
    check("t2_lone_term_err", 64'(bus.err), 64'd0);
    check("t2_lone_term_ready", 64'(bus.in_ready), 64'd1);
    check("t2_lone_term_ascii", 64'(bus.ASCII), 64'h30303030);

    // 3: illegal character discards the partial word
    send(8'h31);
    check("t3_partial", 64'(bus.ASCII), 64'h30303031);
    send(8'h41);
    check("t3_err_pulse", 64'(bus.err), 64'd1);
    check("t3_ascii_flushed", 64'(bus.ASCII), 64'h30303030);
    send(8'h39);
    check("t3_err_one_cycle", 64'(bus.err), 64'd0);
    send(8'h38);
    send(8'h37);
    send(8'h36);
    bus.in_valid = 1'b0;
    check("t3_out_valid", 64'(bus.out_valid), 64'd1);
    check("t3_ascii", 64'(bus.ASCII), 64'h39383736);
    step();

    // 4: backpressure in HOLD with a pending source byte
    bus.out_ready = 1'b0;
    send(8'h31);
    send(8'h32);
    send(8'h33);
    send(8'h34);
    bus.in_byte = 8'h35;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("t4_hold_valid", 64'(bus.out_valid), 64'd1);
      check("t4_hold_ascii", 64'(bus.ASCII), 64'h31323334);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t4_release_valid", 64'(bus.out_valid), 64'd0);
    check("t4_release_ascii", 64'(bus.ASCII), 64'h30303030);
    check("t4_release_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    check("t4_pending_taken", 64'(bus.ASCII), 64'h30303035);

    // 5: asynchronous reset mid-word, mid-HOLD and during err
    send(8'h31);
    send(8'h32);
    bus.in_valid = 1'b0;
    check("t5_pre_rst_ascii", 64'(bus.ASCII), 64'h30353132);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_midword_ascii", 64'(bus.ASCII), 64'h30303030);
    check("t5_midword_valid", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    step();
    send(8'h31);
    send(8'h32);
    send(8'h33);
    send(8'h34);
    bus.in_valid = 1'b0;
    check("t5_hold_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_hold_rst_valid", 64'(bus.out_valid), 64'd0);
    check("t5_hold_rst_ascii", 64'(bus.ASCII), 64'h30303030);
    check("t5_hold_rst_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    step();
    send(8'h41);
    bus.in_valid = 1'b0;
    check("t5_err_before_rst", 64'(bus.err), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_err_cleared", 64'(bus.err), 64'd0);
    rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    send(8'h35);
    send(8'h36);
    send(8'h37);
    send(8'h38);
    bus.in_valid = 1'b0;
    check("t5_fresh_valid", 64'(bus.out_valid), 64'd1);
    check("t5_fresh_ascii", 64'(bus.ASCII), 64'h35363738);
    step();

`ifdef ASCII_PACK_ERRCNT_EN
    // 6: counter saturation (reset clears the earlier err)
    rst_n = 1'b0;
    #1;
    check("t6_cnt_rst", 64'(err_count), 64'd0);
    rst_n = 1'b1;
    step();
    send(8'h41);
    send(8'h42);
    bus.in_valid = 1'b0;
    step();
    check("t6_cnt_two", 64'(err_count), 64'd2);
    for (int i = 0; i < 298; i++) send(8'h7A);
    bus.in_valid = 1'b0;
    step();
    check("t6_cnt_sat", 64'(err_count), 64'hFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
